// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite shared encodings plus slave FSM state type and byte-lane helper.
// Imported by the memory slave and its testbench.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Lane mask for a legal (size, low address bits) pair, up to 8 lanes.
  function automatic logic [7:0] be_mask(
    input logic [2:0] size,
    input logic [2:0] lsb
  );
    return 8'(((16'd1 << (5'd1 << size)) - 16'd1) << lsb);
  endfunction

endpackage

// File: rtl/ahb3lite_slave_ram.sv
// Word-wide RAM with per-byte write enables.
// One write port, one asynchronous read port; caller registers the read.
module ahb3lite_slave_ram #(
  parameter int DEPTH = 256,
  parameter int DW    = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int NB   = DW / 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [NB-1:0] be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite memory-backed slave with programmable wait states,
// two-cycle ERROR response and write-to-read forwarding.
module ahb3lite_mem_slave
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BYTES     = HDATA_SIZE / 8;
  localparam int ALSB      = $clog2(BYTES);
  localparam int IDXW      = $clog2(MEM_DEPTH);
  localparam int MEM_BYTES = MEM_DEPTH * BYTES;

  slv_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [IDXW-1:0] idx_q;
  logic [ALSB-1:0] lsb_q;
  logic [2:0]      size_q;
  logic            write_q;

  logic [HDATA_SIZE-1:0] rdata_q, rdata_d;
  logic [HDATA_SIZE-1:0] ram_rdata;

  logic                  can_acc;
  logic                  accept;
  logic                  size_ok;
  logic                  align_ok;
  logic                  range_ok;
  logic                  legal;
  logic [HADDR_SIZE-1:0] amask;

  logic            we;
  logic [7:0]      wr_be8;
  logic [BYTES-1:0] wr_be;
  logic            rd_fast;
  logic            rd_slow;
  logic [IDXW-1:0] rd_idx;
  logic            fwd;

  assign can_acc = (state_q == ST_IDLE) ||
                   (state_q == ST_DATA) ||
                   (state_q == ST_ERR2);
  assign accept  = can_acc & HSEL & HREADY & HTRANS[1];

  assign amask    = HADDR_SIZE'((32'd1 << HSIZE) - 32'd1);
  assign size_ok  = HSIZE <= 3'(ALSB);
  assign align_ok = (HADDR & amask) == '0;
  assign range_ok = 32'(HADDR) < 32'(MEM_BYTES);
  assign legal    = size_ok & align_ok & range_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        HRESP   = (state_q == ST_ERR2);
        state_d = ST_IDLE;
        if (accept) begin
          if (!legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_DATA;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lsb_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        idx_q   <= HADDR[ALSB +: IDXW];
        lsb_q   <= HADDR[ALSB-1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
    end
  end

  // Write commits on the last data-phase edge; reads sample the array
  // either at address acceptance or at the final wait edge.
  assign we      = (state_q == ST_DATA) & write_q;
  assign wr_be8  = be_mask(size_q, 3'(lsb_q));
  assign wr_be   = wr_be8[BYTES-1:0];
  assign rd_fast = accept & legal & ~HWRITE & (WAIT_STATES == 0);
  assign rd_slow = (state_q == ST_WAIT) & (cnt_q == 4'd1) & ~write_q;
  assign rd_idx  = (state_q == ST_WAIT) ? idx_q : HADDR[ALSB +: IDXW];
  assign fwd     = we & (rd_idx == idx_q);

  always_comb begin
    rdata_d = rdata_q;
    if (rd_fast | rd_slow) begin
      for (int b = 0; b < BYTES; b++) begin
        rdata_d[b*8 +: 8] = (fwd && wr_be[b]) ? HWDATA[b*8 +: 8]
                                              : ram_rdata[b*8 +: 8];
      end
    end
  end

  assign HRDATA = rdata_q;

  ahb3lite_slave_ram #(
    .DEPTH (MEM_DEPTH),
    .DW    (HDATA_SIZE)
  ) u_ram (
    .clk_i   (HCLK),
    .we_i    (we),
    .be_i    (wr_be),
    .waddr_i (idx_q),
    .wdata_i (HWDATA),
    .raddr_i (rd_idx),
    .rdata_o (ram_rdata)
  );

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], wr_be8};

endmodule
